// File: rtl/apb_exe_pkg.sv
// Shared definitions for the APB execution-unit initiator: register map,
// FSM state encoding and the transfer-index to address mapping.
package apb_exe_pkg;

  // Word addresses of the execution unit's register map
  localparam int unsigned A_ADDR      = 32'h0;
  localparam int unsigned B_ADDR      = 32'h4;
  localparam int unsigned CTRL_ADDR   = 32'h8;
  localparam int unsigned RESULT_ADDR = 32'hC;

  // Width of the ALU opcode carried in CTRL[2:0]
  localparam int OP_W = 3;

  // Index of the final transfer (the RESULT read) in the fixed sequence
  localparam logic [1:0] XFER_LAST = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Address targeted by each step of the write A / write B / write CTRL / read RESULT sequence
  function automatic int unsigned xfer_addr(input logic [1:0] xfer);
    case (xfer)
      2'd0:    return A_ADDR;
      2'd1:    return B_ADDR;
      2'd2:    return CTRL_ADDR;
      default: return RESULT_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/apb_exe_master.sv
// APB initiator that runs one ALU operation on the execution unit:
// writes A, B and CTRL, reads RESULT, and returns result plus status flags.
module apb_exe_master
  import apb_exe_pkg::*;
#(
  parameter int N       = 8,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [N-1:0]      cmd_a,
  input  logic [N-1:0]      cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_result,
  output logic              rsp_error,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_next;
  logic [1:0]        xfer, xfer_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic [N-1:0]      a_q, b_q;
  logic [OP_W-1:0]   op_q;

  logic              accept;
  logic              last_xfer;
  logic              wait_expired;
  logic              slave_err;
  logic              xfer_ok;
  logic [N-1:0]      a_src;
  logic [DATA_W-1:0] a_ext, b_ext, ctrl_word;

  logic              psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d;

  // Only RESULT[N:0] carries information; the remaining read bits are ignored
  logic              unused_prdata;

  assign unused_prdata = ^PRDATA;

  assign cmd_ready    = (state == IDLE) && !rsp_valid;
  assign accept       = cmd_valid && cmd_ready;
  assign last_xfer    = (xfer == XFER_LAST);
  assign wait_expired = (state == ACCESS) && !PREADY && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign slave_err    = (state == ACCESS) && PREADY && PSLVERR;
  assign xfer_ok      = (state == ACCESS) && PREADY && !PSLVERR;

  // Operand A goes on the bus in the same edge it is accepted, so take it straight from the port then
  assign a_src     = accept ? cmd_a : a_q;
  assign a_ext     = {{(DATA_W - N){a_src[N-1]}}, a_src};
  assign b_ext     = {{(DATA_W - N){b_q[N-1]}}, b_q};
  assign ctrl_word = {{(DATA_W - OP_W){1'b0}}, op_q};

  // State register with transfer index, wait counter and latched command
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      xfer     <= 2'd0;
      wait_cnt <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
    end else begin
      state <= state_next;
      xfer  <= xfer_next;
      if (state_next == SETUP) begin
        wait_cnt <= '0;
      end else if (state == ACCESS && !PREADY) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (accept) begin
        a_q  <= cmd_a;
        b_q  <= cmd_b;
        op_q <= cmd_op;
      end
    end
  end

  // Next-state logic: advance through the four transfers, abort on error or timeout
  always_comb begin
    state_next = state;
    xfer_next  = xfer;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SETUP;
          xfer_next  = 2'd0;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (slave_err || wait_expired || (xfer_ok && last_xfer)) begin
          state_next = IDLE;
        end else if (xfer_ok) begin
          state_next = SETUP;
          xfer_next  = xfer + 2'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: next values of the APB signals, loaded with address/data only when a SETUP begins
  always_comb begin
    psel_d    = (state_next != IDLE);
    penable_d = (state_next == ACCESS);
    paddr_d   = PADDR;
    pwrite_d  = PWRITE;
    pwdata_d  = PWDATA;
    if (state_next == SETUP && state != SETUP) begin
      paddr_d  = ADDR_W'(xfer_addr(xfer_next));
      pwrite_d = (xfer_next != XFER_LAST);
      case (xfer_next)
        2'd0:    pwdata_d = a_ext;
        2'd1:    pwdata_d = b_ext;
        2'd2:    pwdata_d = ctrl_word;
        default: pwdata_d = '0;
      endcase
    end
  end

  // Registered APB outputs so the bus never sees combinational glitches
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      PSEL    <= psel_d;
      PENABLE <= penable_d;
      PWRITE  <= pwrite_d;
      PADDR   <= paddr_d;
      PWDATA  <= pwdata_d;
    end
  end

  // Response register: held stable until consumed, loaded on completion or abort
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_error   <= 1'b0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (rsp_valid) begin
      if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end else if (slave_err) begin
      rsp_valid   <= 1'b1;
      rsp_result  <= '0;
      rsp_error   <= 1'b0;
      rsp_slverr  <= 1'b1;
      rsp_timeout <= 1'b0;
    end else if (wait_expired) begin
      rsp_valid   <= 1'b1;
      rsp_result  <= '0;
      rsp_error   <= 1'b0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b1;
    end else if (xfer_ok && last_xfer) begin
      rsp_valid   <= 1'b1;
      rsp_result  <= PRDATA[N-1:0];
      rsp_error   <= PRDATA[N];
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end
  end

endmodule

// File: doc/apb_exe_master.md
# apb_exe_master

APB initiator that drives one ALU operation into the APB execution unit: it accepts a command (operands A, B and opcode) on a valid/ready port, performs the fixed write/write/write/read APB sequence against the unit's register map, and returns the N-bit result with its error flag. It sits between the test/control logic and the APB slave side of the exe unit and is the only bus initiator on that segment.

## Interface
- N, 8: operand/result width; must be ≤ DATA_W-1
- DATA_W, 32: APB data width
- ADDR_W, 4: APB address width
- TIMEOUT, 16: maximum ACCESS cycles with PREADY low before abort (≥1)
- PCLK  in  1  bus clock; all logic on rising edge
- PRESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid && ready
- cmd_a  in  N  operand A (signed)
- cmd_b  in  N  operand B (signed)
- cmd_op  in  3  opcode, written unmodified to CTRL[2:0]
- rsp_valid  out  1  response present, held until rsp_ready
- rsp_ready  in  1  response consumed when valid && ready
- rsp_result  out  N  RESULT[N-1:0] from the read
- rsp_error  out  1  RESULT[N] (ALU error, e.g. negative shift amount)
- rsp_slverr  out  1  a transfer ended with PSLVERR
- rsp_timeout  out  1  a transfer exceeded TIMEOUT wait cycles
- PADDR  out  ADDR_W, PSEL  out  1, PENABLE  out  1, PWRITE  out  1, PWDATA  out  DATA_W
- PRDATA  in  DATA_W, PREADY  in  1, PSLVERR  in  1

## Operation
- Register map (word addresses): A_ADDR=0x0, B_ADDR=0x4, CTRL_ADDR=0x8, RESULT_ADDR=0xC.
- Operands sign-extended to DATA_W in PWDATA; CTRL PWDATA = {zeros, cmd_op}.
- cmd_ready = (state==IDLE) && !rsp_valid. On accept, cmd_a/cmd_b/cmd_op are latched; inputs are don't-care afterwards.
- Sequence index xfer 0..3: write A, write B, write CTRL, read RESULT.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE → SETUP on accept (xfer=0).
  - SETUP → ACCESS unconditionally.
  - ACCESS, PREADY=0: stay; wait counter increments; counter reaching TIMEOUT → abort to IDLE with rsp_timeout=1.
  - ACCESS, PREADY=1, PSLVERR=1: abort to IDLE, rsp_slverr=1, remaining transfers not issued.
  - ACCESS, PREADY=1, PSLVERR=0, xfer<3: xfer++, → SETUP (PSEL stays 1, PENABLE 0).
  - ACCESS, PREADY=1, xfer=3: capture PRDATA, → IDLE, rsp_valid=1.
- On abort: rsp_result=0, rsp_error=0, rsp_valid=1. slverr and timeout are mutually exclusive.
- Wait counter clears on each SETUP.
- rsp_valid stays high with all rsp_* stable until rsp_ready; no new command is accepted while it is high. It clears on the cycle after handshake; cmd_ready rises the same cycle.

## Timing
- Reset values (async assert): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA = 0; cmd_ready=1; rsp_valid, rsp_result, rsp_error, rsp_slverr, rsp_timeout = 0.
- All APB outputs registered. PADDR, PWRITE and PWDATA are stable from SETUP through the completing ACCESS cycle.
- Zero-wait latency: accept at edge 0; SETUP at cycles 1/3/5/7; ACCESS at cycles 2/4/6/8; rsp_valid high at cycle 9. Each wait state adds 1.
- PSEL=0 in IDLE. PENABLE is high only in ACCESS.
- Reset mid-transfer: bus outputs drop immediately. Pending response and latched command are discarded. No resumption.

## Structure
- Package apb_exe_pkg:
  - address constants A_ADDR, B_ADDR, CTRL_ADDR, RESULT_ADDR
  - state enum {IDLE, SETUP, ACCESS}
  - opcode width constant
- Single module. The FSM, xfer index, wait counter and response register are small enough that no sub-module is warranted.

## Test plan
- A=8'h05, B=8'h02, op=3'd4; slave zero-wait, PRDATA=32'h014 → exact 4-transfer address/data sequence, rsp_valid at cycle 9, rsp_result=8'h14, rsp_error=0.
- PREADY low 3 cycles on the B write → PADDR=0x4 and PWDATA stable throughout, rsp_valid at cycle 12.
- PSLVERR=1 on the A write → PSEL low next cycle, no further transfers, rsp_slverr=1, rsp_result=0.
- PREADY held low → abort after 16 ACCESS cycles, rsp_timeout=1, PSEL=0.
- PRDATA=32'h100 (N=8) → rsp_error=1, rsp_result=0. rsp_ready held low 5 cycles → rsp_* stable and cmd_ready=0 until handshake.
- PRESETn low during the CTRL ACCESS → PSEL/PENABLE/rsp_valid 0 immediately. After release, cmd_ready=1 and a new command runs the full sequence.
